// File: rtl/shield_hit_detector_pkg.sv
// rtl/shield_hit_detector_pkg.sv - shared types and limits for the shield hit detector
// Optional feature macro used across the bundle: SHIELD_HIT_STATS_EN.
package shield_pkg;

  typedef enum logic {ARMED, SPENT} hit_state_t;

  localparam int MAX_BOMB_SOURCES = 4;

endpackage

// File: rtl/shield_hit_detector_if.sv
// rtl/shield_hit_detector_if.sv - raster request / collision bundle between drawers and the detector
// SHIELD_HIT_STATS_EN adds the hitCount return signal.
interface shield_hit_detector_if #(
  parameter int BOMB_SOURCES = 2
);
  logic                    startOfFrame;
  logic                    playGame;
  logic                    shieldDR;
  logic                    missileDR;
  logic [BOMB_SOURCES-1:0] bombDR;
  logic                    alienDR;
  logic                    collision;
  logic                    collisionShield_alien;
  logic                    missileHit;
  logic [BOMB_SOURCES-1:0] bombHit;
`ifdef SHIELD_HIT_STATS_EN
  logic [15:0]             hitCount;
`endif

  modport master (
`ifdef SHIELD_HIT_STATS_EN
    input  hitCount,
`endif
    output startOfFrame, playGame, shieldDR, missileDR, bombDR, alienDR,
    input  collision, collisionShield_alien, missileHit, bombHit
  );

  modport slave (
`ifdef SHIELD_HIT_STATS_EN
    output hitCount,
`endif
    input  startOfFrame, playGame, shieldDR, missileDR, bombDR, alienDR,
    output collision, collisionShield_alien, missileHit, bombHit
  );

endinterface

// File: rtl/shield_hit_detector_fsm.sv
// rtl/shield_hit_detector_fsm.sv - per-projectile armed/spent tracker with registered hit pulse
module projectile_hit_fsm
  import shield_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic i_sof,
  input  logic i_play,
  input  logic i_overlap,
  output logic o_strike,
  output logic o_hit
);

  hit_state_t r_state;
  logic       r_hit;

  // Strike is live on the very first overlapping pixel while armed.
  assign o_strike = (r_state == ARMED) & i_overlap;
  assign o_hit    = r_hit;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ARMED;
      r_hit   <= 1'b0;
    end else if (!i_play) begin
      r_state <= ARMED;
      r_hit   <= 1'b0;
    end else if (i_sof) begin
      // Frame start re-arms even when it coincides with an overlap.
      r_state <= ARMED;
      r_hit   <= 1'b0;
    end else if (o_strike) begin
      r_state <= SPENT;
      r_hit   <= 1'b1;
    end else begin
      r_hit   <= 1'b0;
    end
  end

endmodule

// File: rtl/shield_hit_detector.sv
// rtl/shield_hit_detector.sv - shield/projectile and shield/alien overlap detector feeding the shield bitmap
// Optional hit statistics counter enabled by SHIELD_HIT_STATS_EN.
module shield_hit_detector
  import shield_pkg::*;
#(
  parameter int BOMB_SOURCES   = 2,
  parameter bit ALIEN_DEBOUNCE = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetN,
  shield_hit_detector_if.slave  bus
);

  localparam int NSRC = 1 + BOMB_SOURCES;

  logic [NSRC-1:0] w_src_dr;
  logic [NSRC-1:0] w_strike;
  logic [NSRC-1:0] w_hit;
  logic            w_collision;
  logic            w_alien_live;

  // Source 0 is the player missile, sources 1.. are the bombs.
  assign w_src_dr = {bus.bombDR, bus.missileDR};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    projectile_hit_fsm u_fsm (
      .clk       (clk),
      .resetN    (resetN),
      .i_sof     (bus.startOfFrame),
      .i_play    (bus.playGame),
      .i_overlap (w_src_dr[g] & bus.shieldDR & bus.playGame),
      .o_strike  (w_strike[g]),
      .o_hit     (w_hit[g])
    );
  end

  assign w_collision    = resetN & (|w_strike);
  assign bus.collision  = w_collision;
  assign bus.missileHit = w_hit[0];
  assign bus.bombHit    = w_hit[NSRC-1:1];

  assign w_alien_live = bus.alienDR & bus.shieldDR & bus.playGame;

  if (ALIEN_DEBOUNCE) begin : g_alien_latch
    logic r_alien_latch;

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        r_alien_latch <= 1'b0;
      end else if (!bus.playGame || bus.startOfFrame) begin
        r_alien_latch <= 1'b0;
      end else if (w_alien_live) begin
        r_alien_latch <= 1'b1;
      end
    end

    // Live term ORed in so the first overlapping pixel is not delayed.
    assign bus.collisionShield_alien = resetN & bus.playGame & (w_alien_live | r_alien_latch);
  end else begin : g_alien_raw
    assign bus.collisionShield_alien = resetN & w_alien_live;
  end

`ifdef SHIELD_HIT_STATS_EN
  logic        r_play_d;
  logic [15:0] r_hit_count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_play_d    <= 1'b0;
      r_hit_count <= 16'd0;
    end else begin
      r_play_d <= bus.playGame;
      if (r_play_d && !bus.playGame) begin
        r_hit_count <= 16'd0;
      end else if (w_collision && (r_hit_count != 16'hFFFF)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
    end
  end

  assign bus.hitCount = r_hit_count;
`endif

endmodule

// File: tb/tb_shield_hit_detector.sv
// tb/tb_shield_hit_detector.sv - self-checking bench for shield_hit_detector (honours SHIELD_HIT_STATS_EN)
module tb_shield_hit_detector;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  shield_hit_detector_if #(.BOMB_SOURCES(NB)) bus ();

  shield_hit_detector #(.BOMB_SOURCES(NB), .ALIEN_DEBOUNCE(1'b1)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: which projectiles already cratered this frame.
  bit          m_used [NB+1];
  bit          m_pulse[NB+1];
  bit          m_alien_seen;
  int          m_count;
  bit          m_play_prev;
  bit          exp_col, exp_alien, exp_missile;
  logic [NB-1:0] exp_bomb;

  function automatic bit src_dr(int s);
    if (s == 0) return bus.missileDR;
    return bus.bombDR[s-1];
  endfunction

  function automatic void model_clear();
    for (int s = 0; s <= NB; s++) begin
      m_used[s]  = 1'b0;
      m_pulse[s] = 1'b0;
    end
    m_alien_seen = 1'b0;
    m_count      = 0;
    m_play_prev  = 1'b0;
  endfunction

  function automatic void model_commit();
    bit any_crater;
    bit crater;
    any_crater = 1'b0;
    if (!resetN) begin
      model_clear();
      return;
    end
    for (int s = 0; s <= NB; s++) begin
      crater = bus.playGame && bus.shieldDR && src_dr(s) && !m_used[s];
      any_crater |= crater;
      m_pulse[s] = crater && !bus.startOfFrame;
      if (!bus.playGame || bus.startOfFrame) m_used[s] = 1'b0;
      else if (crater) m_used[s] = 1'b1;
    end
    if (!bus.playGame || bus.startOfFrame) m_alien_seen = 1'b0;
    else if (bus.alienDR && bus.shieldDR) m_alien_seen = 1'b1;
    if (m_play_prev && !bus.playGame) m_count = 0;
    else if (any_crater && m_count < 65535) m_count = m_count + 1;
    m_play_prev = bus.playGame;
  endfunction

  function automatic void model_eval();
    exp_col = 1'b0;
    for (int s = 0; s <= NB; s++)
      if (src_dr(s) && !m_used[s]) exp_col = 1'b1;
    exp_col     = resetN && bus.playGame && bus.shieldDR && exp_col;
    exp_alien   = resetN && bus.playGame && ((bus.alienDR && bus.shieldDR) || m_alien_seen);
    exp_missile = resetN && m_pulse[0];
    for (int b = 0; b < NB; b++) exp_bomb[b] = resetN && m_pulse[b+1];
  endfunction

  task automatic drive(input bit sof, input bit play, input bit shield, input bit missile,
                       input logic [NB-1:0] bomb, input bit alien);
    @(posedge clk);
    model_commit();
    #1;
    bus.startOfFrame = sof;
    bus.playGame     = play;
    bus.shieldDR     = shield;
    bus.missileDR    = missile;
    bus.bombDR       = bomb;
    bus.alienDR      = alien;
    @(negedge clk);
    model_eval();
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    model_clear();
    bus.startOfFrame = 1'b0;
    bus.playGame     = 1'b1;
    bus.shieldDR     = 1'b1;
    bus.missileDR    = 1'b1;
    bus.bombDR       = '1;
    bus.alienDR      = 1'b1;
    #3;
    n_total++; if (bus.collision !== 1'b0) $display("FAIL reset_collision got=%b want=0", bus.collision); else n_pass++;
    n_total++; if (bus.collisionShield_alien !== 1'b0) $display("FAIL reset_alien got=%b want=0", bus.collisionShield_alien); else n_pass++;
    n_total++; if (bus.missileHit !== 1'b0) $display("FAIL reset_missileHit got=%b want=0", bus.missileHit); else n_pass++;
    n_total++; if (bus.bombHit !== 2'b00) $display("FAIL reset_bombHit got=%b want=00", bus.bombHit); else n_pass++;
`ifdef SHIELD_HIT_STATS_EN
    n_total++; if (bus.hitCount !== 16'd0) $display("FAIL reset_hitCount got=%0d want=0", bus.hitCount); else n_pass++;
`endif
    @(negedge clk);
    bus.playGame  = 1'b0;
    bus.shieldDR  = 1'b0;
    bus.missileDR = 1'b0;
    bus.bombDR    = '0;
    bus.alienDR   = 1'b0;
    resetN        = 1'b1;
  endtask

  task automatic test_missile_crater();
    drive(1, 1, 0, 0, 2'b00, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 1, 2'b00, 0);
      n_total++; if (bus.collision !== (i == 0)) $display("FAIL crater_collision cyc=%0d got=%b want=%b", i, bus.collision, i == 0); else n_pass++;
      n_total++; if (bus.missileHit !== (i == 1)) $display("FAIL crater_missileHit cyc=%0d got=%b want=%b", i, bus.missileHit, i == 1); else n_pass++;
    end
  endtask

  task automatic test_rearm();
    drive(1, 1, 0, 0, 2'b00, 0);
    drive(0, 1, 1, 1, 2'b00, 0);
    n_total++; if (bus.collision !== 1'b1) $display("FAIL rearm_collision got=%b want=1", bus.collision); else n_pass++;
    drive(0, 1, 1, 1, 2'b00, 0);
    n_total++; if (bus.collision !== 1'b0) $display("FAIL rearm_collision2 got=%b want=0", bus.collision); else n_pass++;
    n_total++; if (bus.missileHit !== 1'b1) $display("FAIL rearm_missileHit got=%b want=1", bus.missileHit); else n_pass++;
  endtask

  task automatic test_simultaneous();
    drive(1, 1, 0, 0, 2'b00, 0);
    drive(0, 1, 1, 1, 2'b10, 0);
    n_total++; if (bus.collision !== 1'b1) $display("FAIL simul_collision got=%b want=1", bus.collision); else n_pass++;
    drive(0, 1, 1, 1, 2'b10, 0);
    n_total++; if (bus.collision !== 1'b0) $display("FAIL simul_collision2 got=%b want=0", bus.collision); else n_pass++;
    n_total++; if (bus.missileHit !== 1'b1) $display("FAIL simul_missileHit got=%b want=1", bus.missileHit); else n_pass++;
    n_total++; if (bus.bombHit !== 2'b10) $display("FAIL simul_bombHit got=%b want=10", bus.bombHit); else n_pass++;
    drive(0, 1, 1, 0, 2'b01, 0);
    n_total++; if (bus.collision !== 1'b1) $display("FAIL simul_bomb0_collision got=%b want=1", bus.collision); else n_pass++;
    n_total++; if (bus.bombHit !== 2'b00) $display("FAIL simul_bombHit_clear got=%b want=00", bus.bombHit); else n_pass++;
  endtask

  task automatic test_sof_priority();
    drive(1, 1, 0, 0, 2'b00, 0);
    drive(1, 1, 1, 1, 2'b00, 0);
    n_total++; if (bus.collision !== 1'b1) $display("FAIL sofprio_collision got=%b want=1", bus.collision); else n_pass++;
    drive(0, 1, 1, 1, 2'b00, 0);
    n_total++; if (bus.missileHit !== 1'b0) $display("FAIL sofprio_missileHit got=%b want=0", bus.missileHit); else n_pass++;
    n_total++; if (bus.collision !== 1'b1) $display("FAIL sofprio_collision2 got=%b want=1", bus.collision); else n_pass++;
    drive(0, 1, 0, 0, 2'b00, 0);
    n_total++; if (bus.missileHit !== 1'b1) $display("FAIL sofprio_missileHit2 got=%b want=1", bus.missileHit); else n_pass++;
  endtask

  task automatic test_alien();
    drive(1, 1, 0, 0, 2'b00, 0);
    drive(0, 1, 1, 0, 2'b00, 1);
    n_total++; if (bus.collisionShield_alien !== 1'b1) $display("FAIL alien_first got=%b want=1", bus.collisionShield_alien); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 2'b00, 0);
      n_total++; if (bus.collisionShield_alien !== 1'b1) $display("FAIL alien_hold cyc=%0d got=%b want=1", i, bus.collisionShield_alien); else n_pass++;
    end
    drive(1, 1, 0, 0, 2'b00, 0);
    drive(0, 1, 0, 0, 2'b00, 0);
    n_total++; if (bus.collisionShield_alien !== 1'b0) $display("FAIL alien_cleared got=%b want=0", bus.collisionShield_alien); else n_pass++;
  endtask

  task automatic test_play_drop();
    drive(1, 1, 0, 0, 2'b00, 0);
    drive(0, 1, 1, 1, 2'b00, 1);
    drive(0, 1, 0, 0, 2'b00, 0);
    n_total++; if (bus.missileHit !== 1'b1) $display("FAIL drop_pre_missileHit got=%b want=1", bus.missileHit); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1, 2'b11, 1);
      n_total++; if (bus.collision !== 1'b0) $display("FAIL drop_collision cyc=%0d got=%b want=0", i, bus.collision); else n_pass++;
      n_total++; if (bus.collisionShield_alien !== 1'b0) $display("FAIL drop_alien cyc=%0d got=%b want=0", i, bus.collisionShield_alien); else n_pass++;
      n_total++; if (bus.missileHit !== 1'b0) $display("FAIL drop_missileHit cyc=%0d got=%b want=0", i, bus.missileHit); else n_pass++;
      n_total++; if (bus.bombHit !== 2'b00) $display("FAIL drop_bombHit cyc=%0d got=%b want=00", i, bus.bombHit); else n_pass++;
    end
    drive(0, 1, 1, 1, 2'b00, 0);
    n_total++; if (bus.collision !== 1'b1) $display("FAIL drop_rearmed_collision got=%b want=1", bus.collision); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(15) == 0, $urandom_range(19) != 0, $urandom_range(1) == 1,
            $urandom_range(9) < 3, {$urandom_range(9) < 3, $urandom_range(9) < 3},
            $urandom_range(9) == 0);
      n_total++; if (bus.collision !== exp_col) $display("FAIL rand_collision i=%0d got=%b want=%b", i, bus.collision, exp_col); else n_pass++;
      n_total++; if (bus.collisionShield_alien !== exp_alien) $display("FAIL rand_alien i=%0d got=%b want=%b", i, bus.collisionShield_alien, exp_alien); else n_pass++;
      n_total++; if (bus.missileHit !== exp_missile) $display("FAIL rand_missileHit i=%0d got=%b want=%b", i, bus.missileHit, exp_missile); else n_pass++;
      n_total++; if (bus.bombHit !== exp_bomb) $display("FAIL rand_bombHit i=%0d got=%b want=%b", i, bus.bombHit, exp_bomb); else n_pass++;
`ifdef SHIELD_HIT_STATS_EN
      n_total++; if (bus.hitCount !== m_count[15:0]) $display("FAIL rand_hitCount i=%0d got=%0d want=%0d", i, bus.hitCount, m_count); else n_pass++;
`endif
    end
  endtask

  task automatic async_reset_pulse();
    #2;
    resetN = 1'b0;
    model_clear();
    #1;
    n_total++; if (bus.collision !== 1'b0) $display("FAIL areset_collision got=%b want=0", bus.collision); else n_pass++;
    n_total++; if (bus.collisionShield_alien !== 1'b0) $display("FAIL areset_alien got=%b want=0", bus.collisionShield_alien); else n_pass++;
    n_total++; if (bus.missileHit !== 1'b0) $display("FAIL areset_missileHit got=%b want=0", bus.missileHit); else n_pass++;
    n_total++; if (bus.bombHit !== 2'b00) $display("FAIL areset_bombHit got=%b want=00", bus.bombHit); else n_pass++;
`ifdef SHIELD_HIT_STATS_EN
    n_total++; if (bus.hitCount !== 16'd0) $display("FAIL areset_hitCount got=%0d want=0", bus.hitCount); else n_pass++;
`endif
    bus.startOfFrame = 1'b0;
    bus.playGame     = 1'b0;
    bus.shieldDR     = 1'b0;
    bus.missileDR    = 1'b0;
    bus.bombDR       = '0;
    bus.alienDR      = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_async_reset();
    drive(1, 1, 0, 0, 2'b00, 0);
    drive(0, 1, 1, 1, 2'b00, 0);
    drive(0, 1, 1, 1, 2'b11, 1);
    n_total++; if (bus.missileHit !== 1'b1) $display("FAIL areset_pre_missileHit got=%b want=1", bus.missileHit); else n_pass++;
    n_total++; if (bus.collision !== 1'b1) $display("FAIL areset_pre_collision got=%b want=1", bus.collision); else n_pass++;
    async_reset_pulse();
  endtask

`ifdef SHIELD_HIT_STATS_EN
  task automatic test_stats();
    for (int f = 0; f < 3; f++) begin
      drive(1, 1, 0, 0, 2'b00, 0);
      drive(0, 1, 1, 1, 2'b00, 0);
      drive(0, 1, 1, 1, 2'b00, 0);
    end
    drive(0, 1, 0, 0, 2'b00, 0);
    n_total++; if (bus.hitCount !== 16'd3) $display("FAIL stats_three got=%0d want=3", bus.hitCount); else n_pass++;
    drive(0, 0, 0, 0, 2'b00, 0);
    drive(0, 0, 0, 0, 2'b00, 0);
    n_total++; if (bus.hitCount !== 16'd0) $display("FAIL stats_newgame got=%0d want=0", bus.hitCount); else n_pass++;
    drive(1, 1, 0, 0, 2'b00, 0);
    drive(0, 1, 1, 1, 2'b00, 0);
    drive(0, 1, 0, 0, 2'b00, 0);
    n_total++; if (bus.hitCount !== 16'd1) $display("FAIL stats_one got=%0d want=1", bus.hitCount); else n_pass++;
    async_reset_pulse();
  endtask
`endif

  initial begin
    test_reset();
    test_missile_crater();
    test_rearm();
    test_simultaneous();
    test_sof_priority();
    test_alien();
    test_play_drop();
    test_random();
    test_async_reset();
`ifdef SHIELD_HIT_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
